// File: rtl/hart_port_scheduler.sv
// Round-robin owner scheduler for the shared memory-controller/MMU port.
// Hands the port over only at a safe point, with one dead cycle between owners.
module hart_port_scheduler #(
    parameter int N_HARTS = 2,
    parameter int QUANTUM = 64,
    parameter int SELW    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_HARTS-1:0] i_req,
    input  logic [N_HARTS-1:0] i_safe,
    input  logic [N_HARTS-1:0] i_lock,
    input  logic               i_mc_busy,
    input  logic               i_freeze,
    output logic [N_HARTS-1:0] o_gnt,
    output logic [SELW-1:0]    o_sel,
    output logic [N_HARTS-1:0] o_busy,
    output logic               o_switch
);

    localparam int QW = $clog2(QUANTUM + 1);
    localparam logic [QW-1:0] QMAX = QW'(QUANTUM);
    localparam logic [N_HARTS-1:0] ONE = N_HARTS'(1);

    typedef enum logic [1:0] {
        GRANT  = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t             state_q;
    logic [N_HARTS-1:0] gnt_q;
    logic [SELW-1:0]    owner_q;
    logic [SELW-1:0]    next_q;
    logic [QW-1:0]      qcnt_q;
    logic               sw_q;

    logic               pend;
    logic               own_req;
    logic               own_safe;
    logic               own_lock;
    logic               want;
    logic               can_sw;
    logic [SELW-1:0]    pick_d;
    logic [SELW-1:0]    idx;
    logic               found;

    // Owner-qualified inputs; gnt_q is one-hot on the owner outside SWITCH
    always_comb begin
        pend     = |(i_req & ~gnt_q);
        own_req  = |(i_req & gnt_q);
        own_safe = |(i_safe & gnt_q);
        own_lock = |(i_lock & gnt_q);
        want     = pend && (!own_req || (qcnt_q >= QMAX));
        can_sw   = own_safe && !own_lock && !i_mc_busy;
    end

    // Next owner: first requester after the current owner, wrapping around
    always_comb begin
        pick_d = owner_q;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k < N_HARTS; k++) begin
            idx = SELW'((int'(owner_q) + k) % N_HARTS);
            if (!found && i_req[idx]) begin
                pick_d = idx;
                found  = 1'b1;
            end
        end
    end

    // Scheduler FSM with registered grant, select and switch pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= GRANT;
            gnt_q   <= ONE;
            owner_q <= '0;
            next_q  <= '0;
            qcnt_q  <= '0;
            sw_q    <= 1'b0;
        end else if (i_freeze) begin
            sw_q <= 1'b0;
        end else begin
            sw_q <= 1'b0;
            unique case (state_q)
                GRANT: begin
                    if (!pend) begin
                        qcnt_q <= '0;
                    end else if (qcnt_q < QMAX) begin
                        qcnt_q <= qcnt_q + 1'b1;
                    end
                    if (want) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        state_q <= GRANT;
                        qcnt_q  <= '0;
                    end else if (can_sw) begin
                        next_q  <= pick_d;
                        gnt_q   <= '0;
                        state_q <= SWITCH;
                    end
                end
                SWITCH: begin
                    owner_q <= next_q;
                    gnt_q   <= ONE << next_q;
                    sw_q    <= 1'b1;
                    qcnt_q  <= '0;
                    state_q <= GRANT;
                end
                default: begin
                    state_q <= GRANT;
                end
            endcase
        end
    end

    assign o_gnt    = gnt_q;
    assign o_sel    = owner_q;
    assign o_busy   = ~gnt_q;
    assign o_switch = sw_q;

endmodule

// File: doc/hart_port_scheduler.md
Name: hart_port_scheduler

Overview:
- Time-multiplexes the single shared memory-controller/MMU port of a multi-hart RV cluster among N_HARTS cores.
- Round-robin grant with a per-owner quantum; ownership changes only at a safe point (owner drained, no atomic/page-walk lock, controller idle).
- Sits between the cores and the port mux. Drives the one-hot grant, the encoded select and the per-hart busy/stall mask.

Parameters:
- N_HARTS, 2, number of requesting harts (>=1).
- QUANTUM, 64, cycles the owner keeps the port while another hart is waiting (>=1).
- SELW, $clog2(N_HARTS) (min 1), width of o_sel.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; asynchronous, active-high.
- i_req  in  N_HARTS  hart g wants the port.
- i_safe  in  N_HARTS  hart g is at a switch point: next state idle, no CSR op in EX/MEM, no exception being taken.
- i_lock  in  N_HARTS  hart g is in an atomic sequence or page walk; the port must not be taken from it.
- i_mc_busy  in  1  memory controller has a transaction in flight.
- i_freeze  in  1  controller is not in CPU mode; scheduler holds all state.
- o_gnt  out  N_HARTS  one-hot grant, registered; all zero only in SWITCH.
- o_sel  out  SELW  index of the current owner, registered.
- o_busy  out  N_HARTS  per-hart stall; 1 for every hart not currently granted.
- o_switch  out  1  one-cycle pulse in the cycle the new grant becomes valid.

Behaviour:
- States: GRANT, DRAIN, SWITCH. All outputs are registered.
- Reset values: state=GRANT, owner=0, o_gnt=1, o_sel=0, o_busy=~1 (hart 0 unstalled), o_switch=0, qcnt=0, next_owner=0.
- Derived signals:
  - pend = |(i_req & ~o_gnt).
  - want = pend && (!i_req[owner] || qcnt >= QUANTUM).
- i_freeze=1: state, owner, qcnt and all outputs hold, and o_switch=0. This takes priority over every transition.
- GRANT:
  - qcnt increments while pend=1, saturating at QUANTUM. qcnt clears when pend=0.
  - Go to DRAIN when want=1.
- DRAIN:
  - Owner stays granted and qcnt holds.
  - If pend drops to 0: return to GRANT and clear qcnt.
  - Else if i_safe[owner] && !i_lock[owner] && !i_mc_busy: latch next_owner and go to SWITCH.
  - next_owner = first g with i_req[g]=1, searching owner+1, owner+2, ... with wrap-around, excluding owner.
  - The inputs are sampled in the same cycle the decision is made.
- SWITCH (exactly one cycle):
  - o_gnt=0 and o_busy=all ones (dead cycle so the port mux settles).
  - Next cycle: owner=next_owner, o_gnt=1<<next_owner, o_sel=next_owner, o_switch=1, qcnt=0, state=GRANT.
  - Requests that drop during SWITCH do not cancel the switch.
- Latency: from want=1 with all safe-point conditions already true, the new grant is visible 3 edges later (GRANT->DRAIN->SWITCH->GRANT).
- Ties: fairness is strict rotation from owner+1. A hart with no request is skipped.
- N_HARTS=1: pend is never 1, so the block stays in GRANT with o_gnt=1 and never pulses o_switch.
- RST asserted mid-operation (including during SWITCH): immediately returns to the reset values. No pulse is produced.
- o_gnt is one-hot or zero in every cycle. o_busy = ~o_gnt always.

Test Plan:
- Reset: assert RST mid-DRAIN with owner=1 -> o_gnt=2'b01, o_sel=0, o_busy=2'b10, o_switch=0 on the same cycle without a clock edge.
- Quantum expiry (N_HARTS=2, QUANTUM=4): i_req=2'b11 and i_safe=2'b11 held -> owner 0 keeps the port; qcnt reaches 4; DRAIN, then SWITCH (o_gnt=00); then o_gnt=2'b10 with a one-cycle o_switch.
- Voluntary release: owner 0 drops i_req while i_req[2]=1 (N_HARTS=4, owner=0, hart 1 idle) -> next_owner=2 and o_gnt=4'b0100 three cycles later; hart 1 is skipped.
- Lock/busy hold: in DRAIN, i_lock[owner]=1 for 10 cycles, then i_mc_busy=1 for 3 cycles -> stays in DRAIN with o_gnt unchanged; switches 2 cycles after both deassert.
- Freeze: i_freeze=1 asserted in GRANT with qcnt=2 for 20 cycles -> qcnt stays 2 and no transition occurs; counting resumes after release.
- Cancel: in DRAIN, the other hart drops i_req -> returns to GRANT, qcnt=0, no SWITCH, o_switch stays 0.
